// File: rtl/sw_load_port.sv
// Switch load port: synchronizes and debounces an 8-bit slide-switch bank
// and exposes the debounced value plus a change flag on a shared,
// tri-stated memory read bus.
module sw_load_port #(
    parameter int         DEBOUNCE  = 4,
    parameter logic [8:0] ADDR_DATA = 9'h140,
    parameter logic [8:0] ADDR_STAT = 9'h141
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [7:0]  SW,
    output logic [15:0] read_data,
    output logic        sw_changed
);

    localparam logic [1:0] CMD_READ = 2'b01;

    // Terminal count of the stability counter; reaching it with a candidate
    // that differs from the debounced value means the candidate is accepted.
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE - 1);

    // Two-flop synchronizer for the asynchronous switch inputs.
    logic [7:0] s1_q, s1_d;
    logic [7:0] s2_q, s2_d;

    // Debounce state.
    logic [7:0] cand_q, cand_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] stable_q, stable_d;
    logic       changed_q, changed_d;

    // Decoded bus accesses and the debounce acceptance strobe.
    logic        rd_data_sel;
    logic        rd_stat_sel;
    logic        accept;
    logic [15:0] rd_value;

    // Synchronizer next state: raw switches enter s1, s1 moves to s2.
    always_comb begin
        s1_d = SW;
        s2_d = s1_q;
    end

    // Debounce: restart on any candidate change, otherwise count stable
    // cycles until the candidate has been steady long enough to accept.
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        accept   = 1'b0;
        if (s2_q != cand_q) begin
            cand_d = s2_q;
            cnt_d  = 8'd0;
        end else if (cand_q != stable_q) begin
            // >= keeps the counter bounded even from an unexpected state.
            if (cnt_q >= CNT_LAST) begin
                stable_d = cand_q;
                cnt_d    = 8'd0;
                accept   = 1'b1;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end else begin
            cnt_d = 8'd0;
        end
    end

    // Bus address decode; only READ commands select this block.
    always_comb begin
        rd_data_sel = (mem_cmd == CMD_READ) && (mem_addr == ADDR_DATA);
        rd_stat_sel = (mem_cmd == CMD_READ) && (mem_addr == ADDR_STAT);
    end

    // Change flag: a data read clears it, a new acceptance sets it, and the
    // set is applied last so it wins when both land on the same edge.
    always_comb begin
        changed_d = changed_q;
        if (rd_data_sel) begin
            changed_d = 1'b0;
        end
        if (accept) begin
            changed_d = 1'b1;
        end
    end

    // Read mux: returns pre-edge register contents combinationally.
    always_comb begin
        rd_value = 16'h0000;
        if (rd_data_sel) begin
            rd_value = {8'h00, stable_q};
        end else if (rd_stat_sel) begin
            rd_value = {15'b0, changed_q};
        end
    end

    assign read_data  = (rd_data_sel || rd_stat_sel) ? rd_value : 16'bz;
    assign sw_changed = changed_q;

    // State registers with synchronous active-low reset overriding updates.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_q      <= 8'd0;
            s2_q      <= 8'd0;
            cand_q    <= 8'd0;
            cnt_q     <= 8'd0;
            stable_q  <= 8'd0;
            changed_q <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            changed_q <= changed_d;
        end
    end

endmodule

// File: tb/tb_sw_load_port.sv
// Self-checking bench for sw_load_port: each cycle the expected read bus
// value and the expected post-edge change flag are queued, then popped and
// compared once the DUT has produced them.
module tb_sw_load_port;

    localparam logic [1:0] NONE  = 2'b00;
    localparam logic [1:0] READ  = 2'b01;
    localparam logic [1:0] WRITE = 2'b10;
    localparam logic [8:0] A_DATA = 9'h140;
    localparam logic [8:0] A_STAT = 9'h141;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [7:0]  SW;
    wire  [15:0] read_data;
    wire         sw_changed;

    typedef struct packed {
        logic [15:0] rd;
        logic        chg;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    sw_load_port #(
        .DEBOUNCE (4),
        .ADDR_DATA(9'h140),
        .ADDR_STAT(9'h141)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_cmd   (mem_cmd),
        .mem_addr  (mem_addr),
        .SW        (SW),
        .read_data (read_data),
        .sw_changed(sw_changed)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] c, input logic [8:0] a);
        mem_cmd  = c;
        mem_addr = a;
    endtask

    // Reset held low with a data read in flight: bus returns zero, flag low.
    task automatic test_reset();
        reset = 1'b0;
        SW    = 8'hA5;
        drive(READ, A_DATA);
        tick();
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({16'h0000, 1'b0});
            #3;
            e = exp_q.pop_front();
            checks++;
            if (read_data !== e.rd) begin
                errors++;
                $display("FAIL reset_rd[%0d]: read_data=%h expected %h", i, read_data, e.rd);
            end
            tick();
            checks++;
            if (sw_changed !== e.chg) begin
                errors++;
                $display("FAIL reset_chg[%0d]: sw_changed=%b expected %b", i, sw_changed, e.chg);
            end
        end
    endtask

    // Release reset with A5 on the switches; reading every cycle, the
    // value appears on edge 7 with the flag set on that same edge.
    task automatic test_accept_latency();
        reset = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            if (k <= 7) begin
                drive(READ, A_DATA);
                exp_q.push_back({16'h0000, (k == 7)});
            end else begin
                drive(NONE, A_DATA);
                exp_q.push_back({16'hzzzz, 1'b1});
            end
            #3;
            e = exp_q.pop_front();
            checks++;
            if (read_data !== e.rd) begin
                errors++;
                $display("FAIL latency_rd[%0d]: read_data=%h expected %h", k, read_data, e.rd);
            end
            tick();
            checks++;
            if (sw_changed !== e.chg) begin
                errors++;
                $display("FAIL latency_chg[%0d]: sw_changed=%b expected %b", k, sw_changed, e.chg);
            end
        end
    endtask

    // Non-read commands and foreign addresses leave the bus floating and
    // the set change flag untouched.
    task automatic test_write_ignored();
        logic [1:0] cmds  [6] = '{WRITE, WRITE, NONE, READ, NONE, READ};
        logic [8:0] addrs [6] = '{A_DATA, A_STAT, A_DATA, 9'h100, A_STAT, 9'h13F};
        for (int i = 0; i < 6; i++) begin
            drive(cmds[i], addrs[i]);
            exp_q.push_back({16'hzzzz, 1'b1});
            #3;
            e = exp_q.pop_front();
            checks++;
            if (read_data !== e.rd) begin
                errors++;
                $display("FAIL ignored_rd[%0d]: read_data=%h expected %h", i, read_data, e.rd);
            end
            tick();
            checks++;
            if (sw_changed !== e.chg) begin
                errors++;
                $display("FAIL ignored_chg[%0d]: sw_changed=%b expected %b", i, sw_changed, e.chg);
            end
        end
    endtask

    // Status read keeps the flag; data read returns A5 and clears it;
    // a following status read shows the cleared flag.
    task automatic test_status();
        logic [8:0]  addrs [3] = '{A_STAT, A_DATA, A_STAT};
        logic [15:0] rds   [3] = '{16'h0001, 16'h00A5, 16'h0000};
        logic        chgs  [3] = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            drive(READ, addrs[i]);
            exp_q.push_back({rds[i], chgs[i]});
            #3;
            e = exp_q.pop_front();
            checks++;
            if (read_data !== e.rd) begin
                errors++;
                $display("FAIL status_rd[%0d]: read_data=%h expected %h", i, read_data, e.rd);
            end
            tick();
            checks++;
            if (sw_changed !== e.chg) begin
                errors++;
                $display("FAIL status_chg[%0d]: sw_changed=%b expected %b", i, sw_changed, e.chg);
            end
        end
    endtask

    // A pulse to FF lasting len cycles (len < DEBOUNCE+1) must be rejected;
    // a final data read confirms A5 is still the debounced value.
    task automatic test_glitch(input int len);
        for (int j = 0; j < len + 10; j++) begin
            SW = (j < len) ? 8'hFF : 8'hA5;
            drive(NONE, A_DATA);
            exp_q.push_back({16'hzzzz, 1'b0});
            #3;
            e = exp_q.pop_front();
            tick();
            checks++;
            if (sw_changed !== e.chg) begin
                errors++;
                $display("FAIL glitch%0d_chg[%0d]: sw_changed=%b expected %b", len, j, sw_changed, e.chg);
            end
        end
        drive(READ, A_DATA);
        exp_q.push_back({16'h00A5, 1'b0});
        #3;
        e = exp_q.pop_front();
        checks++;
        if (read_data !== e.rd) begin
            errors++;
            $display("FAIL glitch%0d_rd: read_data=%h expected %h", len, read_data, e.rd);
        end
        tick();
    endtask

    // Shortest accepted pulse (5 cycles): FF accepted on edge 7, read and
    // cleared on edge 8, A5 re-accepted on edge 12, read back on edge 13.
    task automatic test_min_pulse();
        logic [15:0] rd_exp;
        for (int k = 1; k <= 13; k++) begin
            SW = (k <= 5) ? 8'hFF : 8'hA5;
            if (k == 8) begin
                drive(READ, A_DATA);
                rd_exp = 16'h00FF;
            end else if (k == 13) begin
                drive(READ, A_DATA);
                rd_exp = 16'h00A5;
            end else begin
                drive(NONE, A_DATA);
                rd_exp = 16'hzzzz;
            end
            exp_q.push_back({rd_exp, (k == 7) || (k == 12)});
            #3;
            e = exp_q.pop_front();
            checks++;
            if (read_data !== e.rd) begin
                errors++;
                $display("FAIL pulse_rd[%0d]: read_data=%h expected %h", k, read_data, e.rd);
            end
            tick();
            checks++;
            if (sw_changed !== e.chg) begin
                errors++;
                $display("FAIL pulse_chg[%0d]: sw_changed=%b expected %b", k, sw_changed, e.chg);
            end
        end
    endtask

    // SW moves to 3C, reset hits edges 5 and 6 mid-debounce; afterwards
    // stable is 0 and 3C is accepted on edge 7 after release.
    task automatic test_reset_mid();
        logic [15:0] rd_exp;
        SW = 8'h3C;
        for (int m = 1; m <= 14; m++) begin
            reset = (m == 5 || m == 6) ? 1'b0 : 1'b1;
            drive(READ, A_DATA);
            if (m <= 5)       rd_exp = 16'h00A5;
            else if (m <= 13) rd_exp = 16'h0000;
            else              rd_exp = 16'h003C;
            exp_q.push_back({rd_exp, (m == 13)});
            #3;
            e = exp_q.pop_front();
            checks++;
            if (read_data !== e.rd) begin
                errors++;
                $display("FAIL rstmid_rd[%0d]: read_data=%h expected %h", m, read_data, e.rd);
            end
            tick();
            checks++;
            if (sw_changed !== e.chg) begin
                errors++;
                $display("FAIL rstmid_chg[%0d]: sw_changed=%b expected %b", m, sw_changed, e.chg);
            end
        end
    endtask

    initial begin
        reset    = 1'b0;
        SW       = 8'h00;
        mem_cmd  = NONE;
        mem_addr = 9'h000;
        test_reset();
        test_accept_latency();
        test_write_ignored();
        test_status();
        test_glitch(2);
        test_glitch(4);
        test_min_pulse();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
